// File: rtl/div_seq_ctrl_pkg.sv
// Shared definitions for the DIV/DIVU sequencer: state encoding, latency and
// divide-by-zero constants, plus a two's-complement helper.
package div_seq_ctrl_pkg;

  localparam int          DIV_XLEN      = 32;
  localparam int          DIV_LATENCY   = 35;
  localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_RUN  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } div_state_e;

  function automatic logic [DIV_XLEN-1:0] neg_xlen(input logic [DIV_XLEN-1:0] v);
    return ~v + {{(DIV_XLEN-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/div_seq_ctrl_adder.sv
// Shared 32-bit adder. In subtract mode it computes a - b and reports the
// borrow on cf_o; in add mode cf_o is the ordinary carry out.
module div_seq_ctrl_adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sub_i,
  output logic [W-1:0] sum_o,
  output logic         cf_o
);

  logic [W-1:0] b_eff;
  logic [W:0]   full;

  always_comb begin
    b_eff = sub_i ? ~b_i : b_i;
    full  = {1'b0, a_i} + {1'b0, b_eff} + {{W{1'b0}}, sub_i};
    sum_o = full[W-1:0];
    // A missing carry out of a + ~b + 1 means a borrow occurred.
    cf_o  = full[W] ^ sub_i;
  end

endmodule

// File: rtl/div_seq_ctrl.sv
// Multi-cycle restoring divider sequencer for MIPS DIV/DIVU. One shared adder
// performs a subtract per iteration; quotient goes to LO, remainder to HI.
module div_seq_ctrl
  import div_seq_ctrl_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            sign,
  input  logic            flush,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            div_by_zero
);

  localparam int CNT_W = $clog2(ITER);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  div_state_e      state_q, state_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic            sign_q, sign_d;
  logic [XLEN-1:0] dq_q, dq_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            dbz_flag_q, dbz_flag_d;
  logic [XLEN-1:0] quotient_q, quotient_d;
  logic [XLEN-1:0] remainder_q, remainder_d;
  logic            dbz_q, dbz_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] dvs_abs;
  logic [XLEN-1:0] diff;
  logic            borrow;
  logic            qbit;

  always_comb begin
    shifted = {rem_q[XLEN-2:0], dq_q[XLEN-1]};
    dvs_abs = (sign_q && b_q[XLEN-1]) ? neg_xlen(b_q) : b_q;
    // A set MSB before the shift means the shifted value exceeds 2^XLEN,
    // so the subtraction always succeeds regardless of the borrow.
    qbit    = rem_q[XLEN-1] | ~borrow;
  end

  div_seq_ctrl_adder #(
    .W (XLEN)
  ) u_adder (
    .a_i   (shifted),
    .b_i   (dvs_abs),
    .sub_i (1'b1),
    .sum_o (diff),
    .cf_o  (borrow)
  );

  // NOTE: every next-state signal gets its hold value first so no path through
  // the case statement leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sign_d      = sign_q;
    dq_d        = dq_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    dbz_flag_d  = dbz_flag_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    done_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = dividend;
          b_d     = divisor;
          sign_d  = sign;
          state_d = S_PREP;
        end
      end

      S_PREP: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (b_q == '0) begin
          dq_d       = DIV0_QUOTIENT;
          rem_d      = a_q;
          dbz_flag_d = 1'b1;
          state_d    = S_DONE;
        end else begin
          dq_d       = (sign_q && a_q[XLEN-1]) ? neg_xlen(a_q) : a_q;
          rem_d      = '0;
          cnt_d      = '0;
          dbz_flag_d = 1'b0;
          state_d    = S_RUN;
        end
      end

      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          rem_d = qbit ? diff : shifted;
          dq_d  = {dq_q[XLEN-2:0], qbit};
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == LAST_CNT) begin
            state_d = S_FIX;
          end
        end
      end

      S_FIX: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          if (sign_q && (a_q[XLEN-1] ^ b_q[XLEN-1])) dq_d = neg_xlen(dq_q);
          if (sign_q && a_q[XLEN-1])                 rem_d = neg_xlen(rem_q);
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        quotient_d  = dq_q;
        remainder_d = rem_q;
        dbz_d       = dbz_flag_q;
        done_d      = 1'b1;
        state_d     = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // NOTE: the datapath registers are reset along with the control state; they
  // are few and a clean reset keeps HI/LO deterministic after rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sign_q      <= 1'b0;
      dq_q        <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      dbz_flag_q  <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sign_q      <= sign_d;
      dq_q        <= dq_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      dbz_flag_q  <= dbz_flag_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl: arithmetic vectors, latency, divide by
// zero, ignored start, flush and asynchronous reset mid-operation.
module tb_div_seq_ctrl;
  import div_seq_ctrl_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sign;
  logic        flush;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int n_checks = 0;
  int n_errors = 0;

  div_seq_ctrl #(
    .XLEN (32),
    .ITER (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .sign        (sign),
    .flush       (flush),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Presents start for one cycle; returns #1 after the accepting edge E0.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    dividend = a;
    divisor  = b;
    sign     = sgn;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
  endtask

  // Counts edges from E<from> until done is seen, then checks results.
  task automatic wait_done(input string tag, input int from,
                           input logic [31:0] eq, input logic [31:0] er,
                           input logic edbz, input int elat);
    int  n       = from;
    bit  seen    = 1'b0;
    bit  busy_ok = 1'b1;
    while (n < 100 && !seen) begin
      @(posedge clk);
      #1;
      n++;
      if (done) seen = 1'b1;
      else if (!busy) busy_ok = 1'b0;
    end
    check({tag, " latency"},     32'(n),        32'(elat));
    check({tag, " busy_held"},   32'(busy_ok),  32'd1);
    check({tag, " busy_w_done"}, 32'(busy),     32'd0);
    check({tag, " quotient"},    quotient,      eq);
    check({tag, " remainder"},   remainder,     er);
    check({tag, " div_by_zero"}, 32'(div_by_zero), 32'(edbz));
    @(posedge clk);
    #1;
    check({tag, " done_pulse"},  32'(done),     32'd0);
  endtask

  initial begin
    int done_cnt;
    rst_n    = 1'b1;
    start    = 1'b0;
    sign     = 1'b0;
    flush    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #2 rst_n = 1'b0;
    #1;
    check("reset busy",      32'(busy),        32'd0);
    check("reset done",      32'(done),        32'd0);
    check("reset quotient",  quotient,         32'd0);
    check("reset remainder", remainder,        32'd0);
    check("reset dbz",       32'(div_by_zero), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    launch(32'd100, 32'd7, 1'b0);
    check("divu busy after E0", 32'(busy), 32'd1);
    wait_done("divu 100/7", 0, 32'd14, 32'd2, 1'b0, DIV_LATENCY);

    launch(32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_done("div -7/2", 0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, DIV_LATENCY);

    launch(32'd7, 32'hFFFF_FFFE, 1'b1);
    wait_done("div 7/-2", 0, 32'hFFFF_FFFD, 32'd1, 1'b0, DIV_LATENCY);

    launch(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done("div ovf", 0, 32'h8000_0000, 32'd0, 1'b0, DIV_LATENCY);

    launch(32'hFFFF_FFFF, 32'd1, 1'b0);
    wait_done("divu max/1", 0, 32'hFFFF_FFFF, 32'd0, 1'b0, DIV_LATENCY);

    launch(32'd5, 32'd0, 1'b0);
    wait_done("divu 5/0", 0, 32'hFFFF_FFFF, 32'd5, 1'b1, 2);

    // Second start at E10 with different operands must be ignored.
    launch(32'd100, 32'd7, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    dividend = 32'd999;
    divisor  = 32'd9;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    wait_done("start ignored", 10, 32'd14, 32'd2, 1'b0, DIV_LATENCY);

    // Flush at E20 while in RUN: no done, previous results held.
    launch(32'd1000, 32'd3, 1'b0);
    repeat (19) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush busy drop", 32'(busy), 32'd0);
    done_cnt = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
    end
    check("flush no done",        32'(done_cnt), 32'd0);
    check("flush held quotient",  quotient,      32'd14);
    check("flush held remainder", remainder,     32'd2);

    // Leave div_by_zero and results non-zero, then reset mid-RUN.
    launch(32'd5, 32'd0, 1'b0);
    wait_done("divu 5/0 again", 0, 32'hFFFF_FFFF, 32'd5, 1'b1, 2);
    launch(32'd9, 32'd3, 1'b0);
    repeat (15) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async rst busy",      32'(busy),        32'd0);
    check("async rst done",      32'(done),        32'd0);
    check("async rst quotient",  quotient,         32'd0);
    check("async rst remainder", remainder,        32'd0);
    check("async rst dbz",       32'(div_by_zero), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    launch(32'd9, 32'd3, 1'b0);
    wait_done("after reset 9/3", 0, 32'd3, 32'd0, 1'b0, DIV_LATENCY);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/div_seq_ctrl.md
# div_seq_ctrl

Multi-cycle sequencer for 32-bit MIPS DIV/DIVU. It drives one shared 32-bit subtract-mode adder through 32 restoring-division iterations and produces the quotient (LO) and remainder (HI). It sits beside the ALU in the EX stage. The pipeline stalls on `busy` and writes HI/LO on `done`.

## Interface
Parameters:
- `XLEN`, 32: operand width. Only 32 is supported.
- `ITER`, 32: number of division iterations. Must equal XLEN.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `sign`  in  1  1 = DIV (signed), 0 = DIVU.
- `flush`  in  1  synchronous cancel of the current operation.
- `dividend`  in  32  operand A; captured at start.
- `divisor`  in  32  operand B; captured at start.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse; results valid.
- `quotient`  out  32  LO result; held until the next accepted start.
- `remainder`  out  32  HI result; held until the next accepted start.
- `div_by_zero`  out  1  set with `done` when divisor == 0; held with the results.

## Operation
- Reset values: state IDLE; `busy`, `done`, `div_by_zero` = 0; `quotient`, `remainder` = 0.
- States:
  - IDLE: on `start`, go to PREP and capture operands and `sign`.
  - PREP:
    - divisor == 0: go to DONE.
    - else: load absolute values (only when `sign` and the MSB is set), clear the partial remainder, set count = 0, go to RUN.
  - RUN: one iteration per cycle; after count == 31, go to FIX.
  - FIX: apply signs, go to DONE.
  - DONE: pulse `done`, return to IDLE.
- Iteration:
  - `shifted = {rem[30:0], dq[31]}`.
  - Adder computes `shifted - dvs` (subtract mode; CF = borrow).
  - Success when `rem[31] == 1` OR borrow == 0. On success, `rem = difference` and the quotient bit is 1.
  - On failure, `rem = shifted` and the quotient bit is 0.
  - Every iteration: `dq = {dq[30:0], qbit}`.
- FIX, signed only:
  - Negate the quotient when `a[31] ^ b[31]`.
  - Negate the remainder when `a[31]`.
  - Both are two's-complement, modulo 2^32.
- Divide by zero: `quotient = 0xFFFFFFFF`, `remainder = dividend` (raw, unsigned), `div_by_zero = 1`.
- Signed overflow (0x80000000 / 0xFFFFFFFF): the natural result is required, `quotient = 0x80000000`, `remainder = 0`. No exception.
- `start` outside IDLE is ignored. The pipeline must re-present it.
- `start` in DONE is also ignored. It is accepted on the next IDLE cycle.
- `flush` in PREP/RUN/FIX: return to IDLE next edge, with no `done`. Outputs keep their previous results. `flush` has priority over `start`.
- Reset mid-operation: all state and outputs return to reset values immediately.

## Timing
- `start` sampled at edge E0.
- `busy` is high from E0 (registered, visible after E0) until E35, where it drops. `done` is high for the single cycle after E35.
- Normal latency: 35 edges. PREP = E1, RUN = E2–E33, FIX = E34, DONE = E35.
- Divide by zero: PREP at E1 detects it; `done` after E2.
- `busy` and `done` are never high together.
- Outputs change only at the edge that enters DONE.
- Back-to-back: the earliest next accepted start is the edge after `done`.

## Structure
- The shared header holds:
  - state encoding constants (IDLE=0, PREP=1, RUN=2, FIX=3, DONE=4);
  - `DIV_LATENCY` = 35;
  - `DIV0_QUOTIENT` = 32'hFFFFFFFF.
- One sub-module: the team's existing 32-bit adder, tied to subtract mode. CF is used as the borrow.
- The absolute-value and negation steps are plain combinational logic in this module. They do not use a second adder instance.

## Test plan
- DIVU 100 / 7 -> `quotient` = 14, `remainder` = 2; `done` exactly 35 edges after start; `busy` high in between.
- DIV 0xFFFFFFF9 (−7) / 2 -> `quotient` = 0xFFFFFFFD, `remainder` = 0xFFFFFFFF.
- DIV 7 / 0xFFFFFFFE -> `quotient` = 0xFFFFFFFD, `remainder` = 1.
- DIV 0x80000000 / 0xFFFFFFFF -> `quotient` = 0x80000000, `remainder` = 0.
- DIVU 0xFFFFFFFF / 1 -> `quotient` = 0xFFFFFFFF, `remainder` = 0.
- DIVU 5 / 0 -> `done` after E2; `quotient` = 0xFFFFFFFF, `remainder` = 5, `div_by_zero` = 1.
- Control-path case:
  - `start` with new operands at E10 is ignored; the first result completes unchanged.
  - `flush` at E20 gives no `done` and prior outputs are held.
  - `rst_n` low mid-RUN clears all outputs asynchronously.
